// File: rtl/bike_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bike_pkg
// Description : Shared definitions for the bike computer datapath blocks.
//               Holds the divider operand width and the state encoding used
//               by the divider arbiter.
// Contents    : DIV_WIDTH        - dividend/divisor/quotient width
//               div_arb_state_t  - divider arbiter FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package bike_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_DELIVER    = 3'd4
    } div_arb_state_t;

endpackage : bike_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority search. Starting one
//               position above the pointer and wrapping, returns the first
//               asserted request as a one-hot vector and as an index.
// Ports       : req_i    [N]     - request vector
//               ptr_i    [IDX_W] - index of the most recent winner
//               onehot_o [N]     - one-hot winner (all zero if no request)
//               idx_o    [IDX_W] - winner index
//               valid_o          - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        w_cand   = '0;
        // k runs 1..N so the previous winner is considered last.
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[w_cand]) begin
                valid_o          = 1'b1;
                onehot_o[w_cand] = 1'b1;
                idx_o            = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Shares one sequential divider among NREQ requesters. Grants
//               round-robin, drives the divider start/busy/ready handshake,
//               returns a registered quotient with a one-cycle done pulse,
//               and resolves divide-by-zero and divider timeouts locally.
// Ports       : clk, rst                 - clock, sync active-high reset
//               req [NREQ]               - request levels
//               req_dividend/req_divisor - packed operands, slice i = req i
//               grant [NREQ]             - one-hot owner of the current op
//               done [NREQ]              - one-cycle completion pulse
//               result, err              - quotient and error flag
//               div_start                - start pulse to the divider
//               div_dividend/div_divisor - operands held for the whole op
//               div_busy, div_ready      - divider status
//               div_result               - divider quotient
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter
    import bike_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_busy,
    input  logic                  div_ready,
    input  logic [WIDTH-1:0]      div_result
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Abort decision is taken in the cycle whose count is TIMEOUT-1, so the
    // op leaves the waiting state exactly TIMEOUT cycles after entering it.
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    div_arb_state_t         state_q;
    logic [c_IDX_W-1:0]     ptr_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic [NREQ-1:0]        grant_q;
    logic [NREQ-1:0]        done_q;
    logic [WIDTH-1:0]       result_q;
    logic                   err_q;
    logic                   start_q;
    logic [WIDTH-1:0]       dvd_q;
    logic [WIDTH-1:0]       dvs_q;

    logic [NREQ-1:0]        w_win_onehot;
    logic [c_IDX_W-1:0]     w_win_idx;
    logic                   w_win_valid;
    logic [WIDTH-1:0]       w_sel_dividend;
    logic [WIDTH-1:0]       w_sel_divisor;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (w_win_onehot),
        .idx_o    (w_win_idx),
        .valid_o  (w_win_valid)
    );

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_onehot[i]) begin
                w_sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                w_sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= c_IDX_W'(NREQ - 1);
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
        end else begin
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (w_win_valid) begin
                        grant_q <= w_win_onehot;
                        ptr_q   <= w_win_idx;
                        dvd_q   <= w_sel_dividend;
                        dvs_q   <= w_sel_divisor;
                        if (w_sel_divisor == '0) begin
                            // Divide-by-zero never reaches the divider.
                            result_q <= '1;
                            err_q    <= 1'b1;
                            done_q   <= w_win_onehot & req;
                            state_q  <= ST_DELIVER;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Waiting for busy low keeps a stale op (e.g. one left
                    // running across our reset) from being overlapped.
                    if (!div_busy) begin
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_BUSY;
                    end else if (cnt_q == c_TO_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= grant_q & req;
                        state_q  <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (div_ready) begin
                        // Fast divider: finished before busy was observed.
                        result_q <= div_result;
                        done_q   <= grant_q & req;
                        state_q  <= ST_DELIVER;
                    end else if (div_busy) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_READY;
                    end else if (cnt_q == c_TO_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= grant_q & req;
                        state_q  <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                ST_WAIT_READY: begin
                    if (div_ready) begin
                        result_q <= div_result;
                        done_q   <= grant_q & req;
                        state_q  <= ST_DELIVER;
                    end else if (cnt_q == c_TO_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= grant_q & req;
                        state_q  <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                ST_DELIVER: begin
                    // done/err were registered on entry; they are visible now.
                    grant_q <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign result       = result_q;
    assign err          = err_q;
    assign div_start    = start_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule : div_arbiter
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Directed self-checking bench for div_arbiter with a simple
//               behavioural divider (programmable latency, optional hang).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int W = 16;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor  = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           err;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_busy;
    logic           div_ready;
    logic [W-1:0]   div_result;

    // Divider model controls
    logic           ext_busy = 1'b0;
    logic           hang     = 1'b0;
    int             lat      = 16;
    logic           dm_busy  = 1'b0;
    logic           dm_ready = 1'b0;
    logic [W-1:0]   dm_res   = '0;
    int             dm_cnt   = 0;

    int n_checks = 0;
    int n_errors = 0;

    div_arbiter #(
        .WIDTH   (W),
        .NREQ    (N),
        .TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .grant        (grant),
        .done         (done),
        .result       (result),
        .err          (err),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_ready    (div_ready),
        .div_result   (div_result)
    );

    always #5 clk = ~clk;

    assign div_busy   = dm_busy | ext_busy;
    assign div_ready  = dm_ready;
    assign div_result = dm_res;

    always @(posedge clk) begin
        dm_ready <= 1'b0;
        if (div_start) begin
            dm_busy <= 1'b1;
            dm_cnt  <= lat;
            dm_res  <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
        end else if (dm_busy) begin
            if (dm_cnt <= 1) begin
                dm_busy  <= 1'b0;
                dm_ready <= !hang;
            end else begin
                dm_cnt <= dm_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_dividend[i*W +: W] = W'(a);
        req_divisor[i*W +: W]  = W'(b);
    endtask

    // Advance until done is seen; records cycle count, start pulses seen,
    // cycle of the last div_ready and of the first div_busy.
    task automatic wait_done(input int max, output int cyc, output int starts,
                             output int rdy_at, output int busy_at);
        cyc = 0; starts = 0; rdy_at = -1; busy_at = -1;
        while (done == '0 && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (div_start) starts++;
            if (div_ready) rdy_at = cyc;
            if (div_busy && busy_at < 0) busy_at = cyc;
        end
        if (done == '0) check("done_wait_expired", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, st, ra, ba, dn2, seen;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_result", 32'(result), 0);
        check("rst_start", 32'(div_start), 0);
        rst = 1'b0;
        tick();

        // ---------------- round robin, all requesting ----------------
        lat = 3;
        set_op(0, 100, 10); set_op(1, 200, 10); set_op(2, 300, 10);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_done(60, cyc, st, ra, ba);
            check($sformatf("rr%0d_done", k), 32'(done), 32'(1 << (k % 3)));
            check($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << (k % 3)));
            check($sformatf("rr%0d_result", k), 32'(result), 32'((k % 3 + 1) * 10));
            if (k == 5) req = '0;
            tick();
        end
        check("rr_idle_grant", 32'(grant), 0);

        // ---------------- single request 1000/8 ----------------
        lat = 16;
        set_op(0, 1000, 8);
        req = 3'b001;
        wait_done(80, cyc, st, ra, ba);
        check("single_done", 32'(done), 32'h1);
        check("single_result", 32'(result), 125);
        check("single_err", 32'(err), 0);
        check("single_starts", 32'(st), 1);
        check("single_done_after_ready", 32'(cyc - ra), 1);
        req = '0;
        tick();
        check("single_done_pulse", 32'(done), 0);
        check("single_grant_clear", 32'(grant), 0);
        check("single_result_held", 32'(result), 125);

        // ---------------- divide by zero ----------------
        set_op(1, 77, 0);
        req = 3'b010;
        wait_done(10, cyc, st, ra, ba);
        check("dz_latency", 32'(cyc), 1);
        check("dz_done", 32'(done), 32'h2);
        check("dz_result", 32'(result), 32'hFFFF);
        check("dz_err", 32'(err), 1);
        check("dz_no_start", 32'(st), 0);
        req = '0;
        tick();
        check("dz_err_one_cycle", 32'(err), 0);
        check("dz_result_held", 32'(result), 32'hFFFF);

        // ---------------- timeout in WAIT_READY ----------------
        hang = 1'b1; lat = 4;
        set_op(0, 50, 5);
        req = 3'b001;
        wait_done(100, cyc, st, ra, ba);
        check("to_done", 32'(done), 32'h1);
        check("to_result", 32'(result), 0);
        check("to_err", 32'(err), 1);
        // WAIT_READY is entered the cycle after busy is first visible.
        check("to_latency", 32'(cyc - ba), 21);
        req = '0; hang = 1'b0;
        tick();

        // ---------------- busy at issue, then withdrawal ----------------
        lat = 16;
        set_op(2, 90, 9);
        ext_busy = 1'b1;
        req = 3'b100;
        tick();
        check("busy_grant", 32'(grant), 32'h4);
        st = div_start ? 1 : 0;
        repeat (4) begin
            tick();
            if (div_start) st++;
        end
        check("busy_no_start", 32'(st), 0);
        ext_busy = 1'b0;
        tick();
        check("start_after_busy", 32'(div_start), 1);
        req = '0;
        dn2 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done[2]) dn2++;
        end
        check("withdraw_no_done", 32'(dn2), 0);
        check("withdraw_released", 32'(grant), 0);
        set_op(0, 144, 12);
        req = 3'b001;
        wait_done(80, cyc, st, ra, ba);
        check("after_withdraw_done", 32'(done), 32'h1);
        check("after_withdraw_result", 32'(result), 12);
        req = '0;
        tick();

        // ---------------- reset mid-operation ----------------
        set_op(1, 90, 3);
        req = 3'b010;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            tick();
            if (div_busy) seen = 1;
        end
        check("midrst_busy_seen", 32'(seen), 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("midrst_grant", 32'(grant), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_start", 32'(div_start), 0);
        rst = 1'b0;
        req = 3'b110;
        tick();
        check("post_rst_grant", 32'(grant), 32'h2);
        wait_done(80, cyc, st, ra, ba);
        check("post_rst_done", 32'(done), 32'h2);
        check("post_rst_result", 32'(result), 30);
        req = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_div_arbiter
`default_nettype wire
